flick_conditioner: RTL and testbench

- Input conditioning stage directly upstream of the bound flasher.
- Takes the raw, asynchronous, possibly bouncing `flick_raw` button signal and synchronizes it into `clk`.
- Debounces it with a counter-based state machine, then drives a clean level (`flick_out`) into the flasher's `flick` input.
- Also provides one-cycle edge pulses and a saturating count of rejected glitches for debug.

---
 rtl/flick_if.sv | 11 +
 rtl/flick_conditioner.sv | 80 ++++++++
 tb/tb_flick_conditioner.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/flick_if.sv
// flick_if: button-in / conditioned-level-out bundle between a driver and flick_conditioner.
interface flick_if;
   logic       flick_raw;
   logic       glitch_clr;
   logic       flick_out;
   logic       flick_rise;
   logic       flick_fall;
   logic [7:0] glitch_cnt;
   modport master (output flick_raw, glitch_clr, input flick_out, flick_rise, flick_fall, glitch_cnt);
   modport slave (input flick_raw, glitch_clr, output flick_out, flick_rise, flick_fall, glitch_cnt);
endinterface

// File: rtl/flick_conditioner.sv
// flick_conditioner: synchronizes and debounces a raw button into a clean level, edge pulses and a glitch count.
module flick_conditioner #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 8
) (
   input logic   clk,
   input logic   reset,
   flick_if.slave f
);
   typedef enum logic [1:0] {IDLE_LOW, CHK_HIGH, HOLD_HIGH, CHK_LOW} state_t;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   out_q, out_d, rise_q, rise_d, fall_q, fall_d;
   logic [7:0]             glitch_q, glitch_d;
   logic                   s, abort;
   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], f.flick_raw};
      s       = sync_q[SYNC_STAGES-1];
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      abort   = 1'b0;
      case (state_q)
         IDLE_LOW: if (s) begin
            state_d = CHK_HIGH;
            cnt_d   = CNT_W'(1);
         end
         CHK_HIGH: if (!s) begin
            state_d = IDLE_LOW;
            abort   = 1'b1;
         end else if (cnt_q == LAST) begin
            state_d = HOLD_HIGH;
            out_d   = 1'b1;
            rise_d  = 1'b1;
         end else cnt_d = cnt_q + CNT_W'(1);
         HOLD_HIGH: if (!s) begin
            state_d = CHK_LOW;
            cnt_d   = CNT_W'(1);
         end
         CHK_LOW: if (s) begin
            state_d = HOLD_HIGH;
            abort   = 1'b1;
         end else if (cnt_q == LAST) begin
            state_d = IDLE_LOW;
            out_d   = 1'b0;
            fall_d  = 1'b1;
         end else cnt_d = cnt_q + CNT_W'(1);
      endcase
      // clear wins over a same-cycle abort
      glitch_d = f.glitch_clr ? 8'd0 : (abort && glitch_q != 8'hff) ? glitch_q + 8'd1 : glitch_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE_LOW;
         sync_q   <= '0;
         cnt_q    <= '0;
         out_q    <= 1'b0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
         glitch_q <= 8'd0;
      end else begin
         state_q  <= state_d;
         sync_q   <= sync_d;
         cnt_q    <= cnt_d;
         out_q    <= out_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         glitch_q <= glitch_d;
      end
   end
   assign f.flick_out  = out_q;
   assign f.flick_rise = rise_q;
   assign f.flick_fall = fall_q;
   assign f.glitch_cnt = glitch_q;
endmodule

// File: tb/tb_flick_conditioner.sv
// tb_flick_conditioner: scenario tasks drive the button; a run-length reference model queues expected outputs per edge.
module tb_flick_conditioner;
   localparam int SYNC = 2;
   localparam int DEB  = 4;
   typedef struct {bit o; bit r; bit f; int g;} exp_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   flick_if fi();
   flick_conditioner #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .CNT_W(8)) dut (.clk(clk), .reset(reset), .f(fi.slave));
   always #5 clk = ~clk;
   exp_t sb[$];
   exp_t e;
   bit [SYNC-1:0] pipe;
   int run, m_gl;
   bit m_out, m_rise, m_fall;
   int checks = 0, errors = 0;
   int rises, falls, rise_at, fall_at;
   bit seen_high;
   task automatic tick(input bit r, input bit c, input bit rs);
      exp_t x;
      bit s;
      fi.flick_raw = r;
      fi.glitch_clr = c;
      reset = rs;
      @(posedge clk);
      if (rs) begin
         pipe = '0; run = 0; m_out = 0; m_rise = 0; m_fall = 0; m_gl = 0;
      end else begin
         s = pipe[SYNC-1];
         pipe = {pipe[SYNC-2:0], r};
         m_rise = 0;
         m_fall = 0;
         if (s != m_out) begin
            run++;
            if (run == DEB) begin
               m_out = s; m_rise = s; m_fall = !s; run = 0;
            end
         end else begin
            if (run > 0 && m_gl < 255) m_gl++;
            run = 0;
         end
         if (c) m_gl = 0;
      end
      x.o = m_out; x.r = m_rise; x.f = m_fall; x.g = m_gl;
      sb.push_back(x);
      #1;
   endtask
   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         tick(0, 0, 1);
         e = sb.pop_front();
         checks++;
         if ({fi.flick_out, fi.flick_rise, fi.flick_fall, fi.glitch_cnt} !== {e.o, e.r, e.f, 8'(e.g)} || fi.glitch_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset: got out=%b rise=%b fall=%b cnt=%0d exp all 0", fi.flick_out, fi.flick_rise, fi.flick_fall, fi.glitch_cnt);
         end
      end
   endtask
   task automatic test_clean_press();
      rises = 0; rise_at = -1;
      for (int i = 0; i < 20; i++) begin
         tick(1, 0, 0);
         e = sb.pop_front();
         checks++;
         if ({fi.flick_out, fi.flick_rise, fi.flick_fall, fi.glitch_cnt} !== {e.o, e.r, e.f, 8'(e.g)}) begin
            errors++;
            $display("FAIL clean_press[%0d]: got %b%b%b/%0d exp %b%b%b/%0d", i, fi.flick_out, fi.flick_rise, fi.flick_fall, fi.glitch_cnt, e.o, e.r, e.f, e.g);
         end
         if (fi.flick_rise) rises++;
         if (fi.flick_out && rise_at < 0) rise_at = i;
      end
      checks++;
      if (rise_at != 5) begin errors++; $display("FAIL clean_press_latency: got edge %0d exp 5", rise_at); end
      checks++;
      if (rises != 1) begin errors++; $display("FAIL clean_press_rises: got %0d exp 1", rises); end
      checks++;
      if (fi.glitch_cnt !== 8'd0) begin errors++; $display("FAIL clean_press_glitch: got %0d exp 0", fi.glitch_cnt); end
      falls = 0;
      for (int i = 0; i < 20; i++) begin
         tick(0, 0, 0);
         e = sb.pop_front();
         checks++;
         if ({fi.flick_out, fi.flick_rise, fi.flick_fall, fi.glitch_cnt} !== {e.o, e.r, e.f, 8'(e.g)}) begin
            errors++;
            $display("FAIL clean_release[%0d]: got %b%b%b/%0d exp %b%b%b/%0d", i, fi.flick_out, fi.flick_rise, fi.flick_fall, fi.glitch_cnt, e.o, e.r, e.f, e.g);
         end
         if (fi.flick_fall) falls++;
      end
      checks++;
      if (falls != 1 || fi.flick_out !== 1'b0) begin errors++; $display("FAIL clean_release: got falls=%0d out=%b exp 1/0", falls, fi.flick_out); end
   endtask
   task automatic test_bounce_press();
      bit pat [21];
      pat = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
      rises = 0; rise_at = -1;
      for (int i = 0; i < 21; i++) begin
         tick(pat[i], 0, 0);
         e = sb.pop_front();
         checks++;
         if ({fi.flick_out, fi.flick_rise, fi.flick_fall, fi.glitch_cnt} !== {e.o, e.r, e.f, 8'(e.g)}) begin
            errors++;
            $display("FAIL bounce_press[%0d]: got %b%b%b/%0d exp %b%b%b/%0d", i, fi.flick_out, fi.flick_rise, fi.flick_fall, fi.glitch_cnt, e.o, e.r, e.f, e.g);
         end
         if (fi.flick_rise) rises++;
         if (fi.flick_out && rise_at < 0) rise_at = i;
      end
      checks++;
      if (rise_at != 10 || rises != 1) begin errors++; $display("FAIL bounce_press_rise: got edge %0d rises %0d exp 10/1", rise_at, rises); end
      checks++;
      if (fi.glitch_cnt !== 8'd2) begin errors++; $display("FAIL bounce_press_glitch: got %0d exp 2", fi.glitch_cnt); end
   endtask
   task automatic test_release_bounce();
      bit pat [20];
      pat = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      falls = 0; fall_at = -1;
      for (int i = 0; i < 20; i++) begin
         tick(pat[i], 0, 0);
         e = sb.pop_front();
         checks++;
         if ({fi.flick_out, fi.flick_rise, fi.flick_fall, fi.glitch_cnt} !== {e.o, e.r, e.f, 8'(e.g)}) begin
            errors++;
            $display("FAIL release_bounce[%0d]: got %b%b%b/%0d exp %b%b%b/%0d", i, fi.flick_out, fi.flick_rise, fi.flick_fall, fi.glitch_cnt, e.o, e.r, e.f, e.g);
         end
         if (fi.flick_fall) falls++;
         if (!fi.flick_out && fall_at < 0) fall_at = i;
      end
      checks++;
      if (fall_at != 7 || falls != 1) begin errors++; $display("FAIL release_bounce_fall: got edge %0d falls %0d exp 7/1", fall_at, falls); end
      checks++;
      if (fi.glitch_cnt !== 8'd3) begin errors++; $display("FAIL release_bounce_glitch: got %0d exp 3", fi.glitch_cnt); end
   endtask
   task automatic test_short_glitches();
      seen_high = 0;
      for (int p = 0; p < 300; p++)
         for (int i = 0; i < 12; i++) begin
            tick(i < 2, 0, 0);
            e = sb.pop_front();
            checks++;
            if ({fi.flick_out, fi.flick_rise, fi.flick_fall, fi.glitch_cnt} !== {e.o, e.r, e.f, 8'(e.g)}) begin
               errors++;
               $display("FAIL short_glitch[%0d.%0d]: got %b%b%b/%0d exp %b%b%b/%0d", p, i, fi.flick_out, fi.flick_rise, fi.flick_fall, fi.glitch_cnt, e.o, e.r, e.f, e.g);
            end
            if (fi.flick_out) seen_high = 1;
         end
      checks++;
      if (seen_high) begin errors++; $display("FAIL short_glitch_out: got flick_out high exp always 0"); end
      checks++;
      if (fi.glitch_cnt !== 8'd255) begin errors++; $display("FAIL short_glitch_sat: got %0d exp 255", fi.glitch_cnt); end
      tick(0, 1, 0);
      e = sb.pop_front();
      checks++;
      if (fi.glitch_cnt !== 8'd0 || fi.glitch_cnt !== 8'(e.g)) begin errors++; $display("FAIL glitch_clr: got %0d exp 0", fi.glitch_cnt); end
   endtask
   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) begin
         tick(1, 0, 0);
         e = sb.pop_front();
         checks++;
         if ({fi.flick_out, fi.flick_rise, fi.flick_fall, fi.glitch_cnt} !== {e.o, e.r, e.f, 8'(e.g)}) begin
            errors++;
            $display("FAIL reset_mid_pre[%0d]: got %b%b%b/%0d exp %b%b%b/%0d", i, fi.flick_out, fi.flick_rise, fi.flick_fall, fi.glitch_cnt, e.o, e.r, e.f, e.g);
         end
      end
      tick(1, 0, 1);
      e = sb.pop_front();
      checks++;
      if ({fi.flick_out, fi.flick_rise, fi.flick_fall, fi.glitch_cnt} !== 11'd0) begin
         errors++;
         $display("FAIL reset_mid_clear: got %b%b%b/%0d exp 000/0", fi.flick_out, fi.flick_rise, fi.flick_fall, fi.glitch_cnt);
      end
      rises = 0; rise_at = -1;
      for (int i = 0; i < 12; i++) begin
         tick(1, 0, 0);
         e = sb.pop_front();
         checks++;
         if ({fi.flick_out, fi.flick_rise, fi.flick_fall, fi.glitch_cnt} !== {e.o, e.r, e.f, 8'(e.g)}) begin
            errors++;
            $display("FAIL reset_mid_post[%0d]: got %b%b%b/%0d exp %b%b%b/%0d", i, fi.flick_out, fi.flick_rise, fi.flick_fall, fi.glitch_cnt, e.o, e.r, e.f, e.g);
         end
         if (fi.flick_rise) begin rises++; if (rise_at < 0) rise_at = i; end
      end
      checks++;
      if (rise_at != 5 || rises != 1) begin errors++; $display("FAIL reset_mid_rise: got edge %0d rises %0d exp 5/1", rise_at, rises); end
   endtask
   task automatic test_clear_collision();
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < 8; i++) begin
            tick(i != 0, pass == 1 && i == 3, 0);
            e = sb.pop_front();
            checks++;
            if ({fi.flick_out, fi.flick_rise, fi.flick_fall, fi.glitch_cnt} !== {e.o, e.r, e.f, 8'(e.g)}) begin
               errors++;
               $display("FAIL clr_collision[%0d.%0d]: got %b%b%b/%0d exp %b%b%b/%0d", pass, i, fi.flick_out, fi.flick_rise, fi.flick_fall, fi.glitch_cnt, e.o, e.r, e.f, e.g);
            end
            if (i == 3) begin
               checks++;
               if (fi.glitch_cnt !== (pass == 0 ? 8'd1 : 8'd0)) begin
                  errors++;
                  $display("FAIL clr_collision_edge[%0d]: got %0d exp %0d", pass, fi.glitch_cnt, pass == 0 ? 1 : 0);
               end
            end
         end
      end
   endtask
   initial begin
      fi.flick_raw = 0;
      fi.glitch_clr = 0;
      test_reset();
      test_clean_press();
      test_bounce_press();
      test_release_bounce();
      test_short_glitches();
      test_reset_mid();
      test_clear_collision();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
   initial begin
      #1ms;
      $display("FAIL timeout: got no completion exp finish within 1ms");
      $fatal(1, "timeout");
   end
endmodule
